// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the serial program loader.
//   state_t    - load FSM states
//   DATA_BITS  - data bits per UART frame
//   STOP_BITS  - stop bits per UART frame
//   HDR_BYTES  - length header size in bytes (big-endian)
package prog_loader_pkg;
   typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERR} state_t;
   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;
   localparam int HDR_BYTES = 2;
endpackage

// File: rtl/prog_loader_uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with a 2-FF input synchronizer.
//   clock, reset  - system clock, asynchronous active-high reset
//   rx            - raw serial input, idle high
//   rx_valid      - 1-cycle pulse after a good stop-bit sample
//   rx_data       - received byte, valid with rx_valid
//   rx_frame_err  - 1-cycle pulse when the stop bit samples low
//   rx_busy       - a frame is in progress
//   rx_s          - synchronized line level
module uart_rx_byte
   import prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic       rx_valid,
   output logic [7:0] rx_data,
   output logic       rx_frame_err,
   output logic       rx_busy,
   output logic       rx_s
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int LAST = DATA_BITS + STOP_BITS;
   localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
   logic rx_m, rx_p, tick;
   logic [CW-1:0] cnt;
   logic [3:0] idx;
   logic [7:0] shift;
   // idx 0 is the start bit, checked half a bit in; later bits are a full bit apart
   assign tick = rx_busy && cnt == (idx == 4'd0 ? HALF_M1 : FULL_M1);
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_p <= 1'b1;
         cnt <= '0;
         idx <= '0;
         shift <= '0;
         rx_busy <= 1'b0;
         rx_valid <= 1'b0;
         rx_frame_err <= 1'b0;
         rx_data <= '0;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_p <= rx_s;
         rx_valid <= 1'b0;
         rx_frame_err <= 1'b0;
         if (!rx_busy) begin
            cnt <= '0;
            idx <= '0;
            rx_busy <= rx_p & ~rx_s;
         end else if (tick) begin
            cnt <= '0;
            idx <= idx + 4'd1;
            if (idx == 4'd0)
               rx_busy <= ~rx_s;
            else if (idx == 4'(LAST)) begin
               rx_busy <= 1'b0;
               rx_valid <= rx_s;
               rx_frame_err <= ~rx_s;
               if (rx_s) rx_data <= shift;
            end else if (idx <= 4'(DATA_BITS))
               shift <= {rx_s, shift[7:1]};
         end else
            cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed program from a UART stream into program memory.
//   clock, reset  - system clock, asynchronous active-high reset
//   rx            - UART serial input, idle high
//   start_load    - 1-cycle pulse arming a load
//   mem_we/mem_addr/mem_wdata - program memory write port
//   cpu_reset     - holds the CPU in reset while loading or after an error
//   loading, done, frame_err  - load status
//   byte_count    - data bytes written in the current load
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W = 12,
   parameter int DEPTH = 2 ** ADDR_W,
   parameter int TIMEOUT_BITS = 64
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              rx,
   input  logic              start_load,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              cpu_reset,
   output logic              loading,
   output logic              done,
   output logic              frame_err,
   output logic [ADDR_W:0]   byte_count
);
   localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW = $clog2(TO + 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   state_t state, state_n;
   logic rx_valid, rx_frame_err, rx_busy, rx_s, active, line_idle, we_n;
   logic [7:0] rx_data, len_hi, len_hi_n, wdata_n;
   logic [15:0] len16;
   logic [ADDR_W:0] len, len_n, count_n;
   logic [ADDR_W-1:0] addr_n;
   logic [TW-1:0] timer, timer_n;
   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clock(clock),
      .reset(reset),
      .rx(rx),
      .rx_valid(rx_valid),
      .rx_data(rx_data),
      .rx_frame_err(rx_frame_err),
      .rx_busy(rx_busy),
      .rx_s(rx_s)
   );
   assign len16 = {len_hi, rx_data};
   assign active = state inside {LEN_HI, LEN_LO, DATA};
   assign line_idle = rx_s & ~rx_busy;
   // idle-gap timer: held at zero outside a load and whenever a frame is under way
   assign timer_n = (active && line_idle) ? timer + 1'b1 : '0;
   always_comb begin
      state_n = state;
      len_hi_n = len_hi;
      len_n = len;
      addr_n = mem_addr;
      count_n = byte_count;
      we_n = 1'b0;
      wdata_n = mem_wdata;
      case (state)
         LEN_HI: if (rx_valid) begin
            len_hi_n = rx_data;
            state_n = LEN_LO;
         end
         LEN_LO: if (rx_valid) begin
            len_n = len16[ADDR_W:0];
            state_n = (len16 != 16'd0 && len16 <= 16'(DEPTH)) ? DATA : ERR;
         end
         DATA: if (rx_valid) begin
            we_n = 1'b1;
            wdata_n = rx_data;
         end else if (mem_we) begin
            // advance the cycle after the strobe; the address saturates at the top
            count_n = byte_count + 1'b1;
            addr_n = (mem_addr == LAST_ADDR) ? mem_addr : mem_addr + 1'b1;
            if (count_n == len) state_n = DONE;
         end
         default: if (start_load) begin
            state_n = LEN_HI;
            addr_n = '0;
            count_n = '0;
         end
      endcase
      if (active && (rx_frame_err || (line_idle && timer == TW'(TO - 1)))) state_n = ERR;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         len_hi <= '0;
         len <= '0;
         timer <= '0;
         mem_we <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         byte_count <= '0;
         cpu_reset <= 1'b0;
         loading <= 1'b0;
         done <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state <= state_n;
         len_hi <= len_hi_n;
         len <= len_n;
         timer <= timer_n;
         mem_we <= we_n;
         mem_addr <= addr_n;
         mem_wdata <= wdata_n;
         byte_count <= count_n;
         cpu_reset <= state_n inside {LEN_HI, LEN_LO, DATA, ERR};
         loading <= state_n inside {LEN_HI, LEN_LO, DATA};
         done <= state_n == DONE;
         // ERR is only left through start_load, so the flag is sticky until then
         frame_err <= state_n == ERR;
      end
   end
endmodule
